// File: rtl/result_uart_tx.sv
// result_uart_tx: captures lowest/highest/hitvector on flashin and sends them as a framed 8N1 UART packet
//   clock, reset (async, active low)
//   lowest, highest, hitvector, flashin : result capture (flashin is a one-cycle strobe)
//   tx : serial line, idle high | busy, done, overrun : packet status
//   RESULT_TX_CHECKSUM_EN appends an XOR checksum byte of bytes 1..6
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter logic [7:0] HEADER = 8'hAA
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] lowest,
  input  logic [15:0] highest,
  input  logic [15:0] hitvector,
  input  logic        flashin,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        overrun
);
`ifdef RESULT_TX_CHECKSUM_EN
  localparam int NB = 8;
`else
  localparam int NB = 7;
`endif
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BYTE = 3'(NB - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0] bit_idx, bit_d, byte_idx, byte_d;
  logic [63:0] pkt, cap;
  logic [7:0] cur;
  logic fin, tx_d, accept, tick;
`ifdef RESULT_TX_CHECKSUM_EN
  assign cap = {lowest[7:0] ^ lowest[15:8] ^ highest[7:0] ^ highest[15:8] ^ hitvector[7:0] ^ hitvector[15:8],
                hitvector, highest, lowest, HEADER};
`else
  assign cap = {8'h00, hitvector, highest, lowest, HEADER};
`endif
  // tx is registered, so the line trails the state by one cycle; fin covers that
  // trailing stop-bit cycle so busy/done line up with the end of the last stop bit
  assign busy = state != IDLE || fin;
  assign accept = flashin && !busy;
  assign tick = cnt == LAST_TICK;
  assign cur = pkt[{byte_idx, 3'b000} +: 8];
  always_comb begin
    state_d = state;
    cnt_d = tick ? '0 : cnt + 1'b1;
    bit_d = bit_idx;
    byte_d = byte_idx;
    tx_d = 1'b1;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = START;
          byte_d = '0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (tick) begin
          state_d = DATA;
          bit_d = '0;
        end
      end
      DATA: begin
        tx_d = cur[bit_idx];
        if (tick) begin
          bit_d = bit_idx + 1'b1;
          state_d = bit_idx == 3'd7 ? STOP : DATA;
        end
      end
      STOP: if (tick) begin
        state_d = byte_idx == LAST_BYTE ? IDLE : START;
        byte_d = byte_idx + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      pkt <= '0;
      tx <= 1'b1;
      fin <= 1'b0;
      done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      bit_idx <= bit_d;
      byte_idx <= byte_d;
      tx <= tx_d;
      fin <= state == STOP && state_d == IDLE;
      done <= fin;
      overrun <= accept ? 1'b0 : overrun | flashin;
      if (accept) pkt <= cap;
    end
endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx: randomized scoreboard bench for result_uart_tx with a UART decoder monitor
module tb_result_uart_tx;
  localparam int CPB = 4;
`ifdef RESULT_TX_CHECKSUM_EN
  localparam int NB = 8;
`else
  localparam int NB = 7;
`endif
  typedef struct { logic [7:0] b; int start; } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [15:0] lowest = '0, highest = '0, hitvector = '0;
  logic flashin = 1'b0;
  logic tx, busy, done, overrun;
  int cyc = 0, checks = 0, errors = 0;
  int exp_a = 0, exp_d = -1;
  logic exp_ovr = 1'b0;
  exp_t q[$];
  result_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hAA)) dut (
    .clock(clock), .reset(reset), .lowest(lowest), .highest(highest), .hitvector(hitvector),
    .flashin(flashin), .tx(tx), .busy(busy), .done(done), .overrun(overrun)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // called at a negedge; flashin is sampled by the following posedge
  task automatic pulse(input logic [15:0] lo, input logic [15:0] hi, input logic [15:0] hv);
    int c;
    logic [7:0] by [8];
    c = cyc;
    lowest = lo;
    highest = hi;
    hitvector = hv;
    flashin = 1'b1;
    @(posedge clock);
    if (c >= exp_d) begin
      by[0] = 8'hAA; by[1] = lo[7:0]; by[2] = lo[15:8]; by[3] = hi[7:0];
      by[4] = hi[15:8]; by[5] = hv[7:0]; by[6] = hv[15:8];
      by[7] = by[1] ^ by[2] ^ by[3] ^ by[4] ^ by[5] ^ by[6];
      for (int i = 0; i < NB; i++) q.push_back('{b: by[i], start: (i == 0) ? c + 2 : -1});
      exp_a = c + 1;
      exp_d = c + 2 + NB * 10 * CPB;
      exp_ovr = 1'b0;
    end else exp_ovr = 1'b1;
    @(negedge clock);
    flashin = 1'b0;
    lowest = 16'($urandom);
    highest = 16'($urandom);
    hitvector = 16'($urandom);
  endtask
  always @(negedge clock) begin
    logic eb;
    eb = reset && cyc >= exp_a && cyc < exp_d;
    chk("busy", busy, eb);
    chk("done", done, reset && cyc == exp_d);
    chk("overrun", overrun, exp_ovr);
    if (!eb) chk("tx_idle", tx, 1);
  end
  initial begin
    int s, idx;
    logic [7:0] b;
    logic stopb;
    bit ab;
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && tx === 1'b0) begin
        s = cyc;
        ab = 1'b0;
        stopb = 1'b0;
        b = '0;
        for (int k = 1; k <= 9 * CPB + CPB / 2; k++) begin
          @(negedge clock);
          if (!reset) begin
            ab = 1'b1;
            break;
          end
          if (k >= CPB + CPB / 2 && (k - CPB / 2) % CPB == 0) begin
            idx = (k - CPB / 2) / CPB - 1;
            if (idx < 8) b[idx] = tx;
            else stopb = tx;
          end
        end
        if (!ab) begin
          if (q.size() == 0) chk("unexpected_byte", {24'h0, b}, 32'hFFFF_FFFF);
          else begin
            e = q.pop_front();
            chk("byte", b, e.b);
            chk("stop_bit", stopb, 1);
            if (e.start >= 0) chk("start_cycle", s, e.start);
          end
        end
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    int target;
    reset = 1'b0;
    flashin = 1'b1;
    repeat (10) begin
      @(negedge clock);
      lowest = 16'($urandom);
      highest = 16'($urandom);
      hitvector = 16'($urandom);
    end
    reset = 1'b1;
    flashin = 1'b0;
    repeat (20) @(negedge clock);
    pulse(16'h1234, 16'hABCD, 16'h00F0);
    repeat (100) @(negedge clock);
    pulse(16'hFFFF, 16'($urandom), 16'($urandom));
    while (cyc < exp_d) @(negedge clock);
    pulse(16'h0001, 16'h0002, 16'h8000);
    while (cyc < exp_d) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      pulse(16'($urandom), 16'($urandom), 16'($urandom));
      repeat ($urandom_range(5, 200)) @(negedge clock);
      if ($urandom_range(0, 1) == 1) pulse(16'($urandom), 16'($urandom), 16'($urandom));
      while (cyc < exp_d) @(negedge clock);
    end
    repeat (5) @(negedge clock);
    pulse(16'($urandom), 16'($urandom), 16'($urandom));
    target = exp_a + 1 + 33 * CPB;
    while (cyc < target) @(negedge clock);
    #2;
    reset = 1'b0;
    q.delete();
    exp_d = -1;
    exp_ovr = 1'b0;
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (50) @(negedge clock);
    pulse(16'($urandom), 16'($urandom), 16'($urandom));
    while (cyc < exp_d) @(negedge clock);
    for (int i = 0; i < 1000 && q.size() != 0; i++) @(negedge clock);
    repeat (5) @(negedge clock);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
Downstream stage of the distance processor. It captures the lowest, highest and hitvector results on the processor's one-cycle flashout strobe and frames them into a fixed byte packet. It then serialises the packet over an 8N1 UART line back to the host. It contains a packet state machine, a byte index counter, a baud-rate counter and a bit counter.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (≥2); 434 gives 115200 baud from 50 MHz
HEADER, 8'hAA, first byte of every packet

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-low reset (0 = in reset)
lowest  input  16  lowest-distance result from the distance processor
highest  input  16  highest-distance result
hitvector  input  16  per-sample hit flags
flashin  input  1  one-cycle result-valid strobe (driven by the processor's flashout)
tx  output  1  UART serial line, idle high
busy  output  1  high while a packet is being sent
done  output  1  one-cycle pulse when the last stop bit of a packet completes
overrun  output  1  sticky flag: flashin arrived while busy

Behaviour:
- Reset (reset=0, async): tx=1, busy=0, done=0, overrun=0, state=IDLE, all counters and latches 0. Asserting reset mid-packet aborts the packet immediately with no partial stop bit; tx goes high asynchronously.
- Packet order: HEADER, lowest[7:0], lowest[15:8], highest[7:0], highest[15:8], hitvector[7:0], hitvector[15:8]. That is 7 bytes.
- Each byte is sent as: start bit (0), data bits LSB first, stop bit (1). Every bit lasts exactly CLKS_PER_BIT cycles.
- There is no idle gap between bytes; the next start bit follows the previous stop bit directly.
- States: IDLE → START → DATA → STOP → (START if bytes remain, else IDLE).
- IDLE: tx=1, busy=0.
  - On posedge with flashin=1, latch all three inputs into the packet register.
  - Set byte index to 0, clear overrun, go to START.
  - busy=1 from the next cycle.
- Latency: tx falls on the first clock edge after the edge that sampled flashin.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit counter 0.
- DATA: tx=current byte[bit]. After CLKS_PER_BIT cycles, advance the bit. After bit 7 expires, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - If this is not the last byte: increment byte index and go to START.
  - If it is the last byte: go to IDLE, assert done for exactly that first IDLE cycle, and drop busy in the same cycle.
- flashin handling:
  - flashin in the cycle done is high is accepted, so back-to-back packets are legal.
  - flashin while busy=1 is ignored for data: the latched packet is unchanged and overrun is set to 1. overrun stays set until the next accepted flashin.
- Input changes after capture have no effect on the packet in flight.
- Frame duration: 70*CLKS_PER_BIT cycles from first start-bit cycle to done (80*CLKS_PER_BIT with CHECKSUM_EN).
- Baud counter width: clog2(CLKS_PER_BIT). Byte index: 3 bits. Bit counter: 3 bits. No arithmetic overflow is possible.

Optional Feature:
- Macro: RESULT_TX_CHECKSUM_EN.
- Defined:
  - An 8th byte is appended after hitvector[15:8]. Its value is the XOR of packet bytes 1..6; HEADER is excluded.
  - The checksum is computed from the latched values at capture.
  - done fires after this byte's stop bit.
- Undefined: the packet is 7 bytes, no checksum logic is synthesised, and port list and timing are otherwise identical.

Test Plan:
- Reset: hold reset=0 with flashin=1 and random inputs → tx=1, busy=0, done=0, overrun=0 throughout. Release reset → still idle; no packet starts without a fresh flashin.
- Single packet: CLKS_PER_BIT=4, lowest=16'h1234, highest=16'hABCD, hitvector=16'h00F0, pulse flashin.
  - Bench UART decoder reads AA 34 12 CD AB F0 00.
  - tx falls 1 cycle after the flashin edge.
  - done pulses once, 280 cycles after the first start-bit cycle.
  - busy falls with done.
- Checksum: same stimulus with RESULT_TX_CHECKSUM_EN defined → 8th byte 8'hB0. done comes after 320 cycles.
- Overrun and capture isolation:
  - Pulse flashin mid-packet with lowest=16'hFFFF → overrun=1, and the packet in flight still carries 34 12.
  - Next accepted flashin clears overrun.
- Back-to-back: assert flashin in the done cycle with new values 16'h0001/16'h0002/16'h8000.
  - The second packet's start bit follows directly.
  - Decoded bytes are AA 01 00 02 00 00 80, and overrun stays 0.
- Reset mid-packet: pull reset low during DATA of byte 3 → tx=1 immediately (async) and busy=0. After release, no residual bits are emitted, and a new flashin produces a complete correct packet.
